// File: rtl/fdiv_issue_arbiter.sv
// Round-robin issue arbiter sharing one non-stallable pipelined fdiv among NREQ requesters.
// Tags ride a fixed-latency pipe alongside the fdiv; results land in credit-gated FIFOs.
module fdiv_issue_arbiter #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned LAT   = 6,
  parameter int unsigned DEPTH = 4
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [32*NREQ-1:0]  req_x1,
  input  logic [32*NREQ-1:0]  req_x2,
  output logic                fdiv_valid,
  output logic [31:0]         fdiv_x1,
  output logic [31:0]         fdiv_x2,
  input  logic                fdiv_out_valid,
  input  logic [31:0]         fdiv_y,
  input  logic                fdiv_ovf,
  input  logic                fdiv_unf,
  output logic [NREQ-1:0]     rsp_valid,
  input  logic [NREQ-1:0]     rsp_ready,
  output logic [32*NREQ-1:0]  rsp_y,
  output logic [NREQ-1:0]     rsp_ovf,
  output logic [NREQ-1:0]     rsp_unf,
  output logic                busy,
  output logic                tag_err
);
  localparam int unsigned IdW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CredW = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned DrnW  = $clog2(LAT + 2);

  localparam logic [DrnW-1:0]  DrainInit = DrnW'(LAT + 1);
  localparam logic [DrnW-1:0]  DrnOne    = DrnW'(1);
  localparam logic [CredW-1:0] CredMax   = CredW'(DEPTH);
  localparam logic [CredW-1:0] CredOne   = CredW'(1);
  localparam logic [PtrW-1:0]  PtrLast   = PtrW'(DEPTH - 1);
  localparam logic [PtrW-1:0]  PtrOne    = PtrW'(1);
  localparam logic [IdW-1:0]   IdLast    = IdW'(NREQ - 1);
  localparam logic [IdW-1:0]   IdOne     = IdW'(1);

  logic [DrnW-1:0] drain_q;
  logic            drain;
  logic [IdW-1:0]  rr_q;
  logic [IdW-1:0]  iss_id_q;
  logic [LAT-1:0]  tv_q;
  logic [IdW-1:0]  tid_q [LAT];
  logic [NREQ-1:0] elig;
  logic [NREQ-1:0] cred_nz;
  logic            gnt_found;
  logic [IdW-1:0]  gnt_id;
  logic [IdW-1:0]  arb_id;
  logic            tail_v;
  logic [IdW-1:0]  tail_id;
  logic            push_any;
  logic            drop_any;
  logic            stray;

  assign drain    = (drain_q != '0);
  assign tail_v   = tv_q[LAT-1];
  assign tail_id  = tid_q[LAT-1];
  // While draining, anything leaving the fdiv belongs to a pre-reset op and is discarded.
  assign push_any = !drain && fdiv_out_valid && tail_v;
  assign drop_any = !drain && !fdiv_out_valid && tail_v;
  assign stray    = !drain && fdiv_out_valid && !tail_v;
  assign busy     = drain || (|cred_nz);

  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    arb_id    = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      arb_id = IdW'((32'(rr_q) + k) % NREQ);
      if (!gnt_found && elig[arb_id]) begin
        gnt_found = 1'b1;
        gnt_id    = arb_id;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_found) begin
      req_ready[gnt_id] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      drain_q    <= DrainInit;
      rr_q       <= '0;
      fdiv_valid <= 1'b0;
      fdiv_x1    <= '0;
      fdiv_x2    <= '0;
      iss_id_q   <= '0;
      tv_q       <= '0;
      tag_err    <= 1'b0;
      for (int k = 0; k < LAT; k++) begin
        tid_q[k] <= '0;
      end
    end else begin
      if (drain) begin
        drain_q <= drain_q - DrnOne;
      end
      fdiv_valid <= gnt_found;
      if (gnt_found) begin
        fdiv_x1  <= req_x1[32*gnt_id +: 32];
        fdiv_x2  <= req_x2[32*gnt_id +: 32];
        iss_id_q <= gnt_id;
        rr_q     <= (gnt_id == IdLast) ? '0 : gnt_id + IdOne;
      end
      // Stage 0 follows the fdiv input register, so the tail lines up with fdiv_out_valid.
      tv_q[0]  <= fdiv_valid;
      tid_q[0] <= iss_id_q;
      for (int k = 1; k < LAT; k++) begin
        tv_q[k]  <= tv_q[k-1];
        tid_q[k] <= tid_q[k-1];
      end
      if (stray || drop_any) begin
        tag_err <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_req
    logic [33:0]      mem_q [DEPTH];
    logic [PtrW-1:0]  wr_q;
    logic [PtrW-1:0]  rd_q;
    logic [CredW-1:0] cnt_q;
    logic [CredW-1:0] cred_q;
    logic [CredW-1:0] cred_d;
    logic             push;
    logic             pop;
    logic             inc;
    logic             drop;

    assign push       = push_any && (tail_id == IdW'(g));
    assign drop       = drop_any && (tail_id == IdW'(g));
    assign inc        = gnt_found && (gnt_id == IdW'(g));
    assign pop        = rsp_valid[g] && rsp_ready[g];
    assign rsp_valid[g] = (cnt_q != '0);
    assign {rsp_y[32*g +: 32], rsp_ovf[g], rsp_unf[g]} = mem_q[rd_q];
    assign elig[g]    = req_valid[g] && (cred_q < CredMax) && !drain;
    assign cred_nz[g] = (cred_q != '0);

    always_comb begin
      cred_d = cred_q;
      if (inc) begin
        cred_d = cred_d + CredOne;
      end
      if (pop) begin
        cred_d = cred_d - CredOne;
      end
      if (drop) begin
        cred_d = cred_d - CredOne;
      end
    end

    // Credits bound occupancy, so a push never finds the FIFO full without a same-cycle pop.
    always_ff @(posedge sys_clk) begin
      if (rst) begin
        wr_q   <= '0;
        rd_q   <= '0;
        cnt_q  <= '0;
        cred_q <= '0;
        for (int k = 0; k < DEPTH; k++) begin
          mem_q[k] <= '0;
        end
      end else begin
        cred_q <= cred_d;
        if (push) begin
          mem_q[wr_q] <= {fdiv_y, fdiv_ovf, fdiv_unf};
          wr_q        <= (wr_q == PtrLast) ? '0 : wr_q + PtrOne;
        end
        if (pop) begin
          rd_q <= (rd_q == PtrLast) ? '0 : rd_q + PtrOne;
        end
        if (push && !pop) begin
          cnt_q <= cnt_q + CredOne;
        end else if (pop && !push) begin
          cnt_q <= cnt_q - CredOne;
        end
      end
    end
  end

endmodule
